// File: rtl/wsc_monitor_if.sv
// Crossing-state bus between the wolf/sheep/cabbage datapath and its monitor.
//   state     : 4-bit crossing state [3]=farmer [2]=wolf [1]=sheep [0]=cabbage
//   done      : far bank reached legally (sticky)
//   error     : an item was eaten (sticky)
//   illegal   : transition was not a legal boat trip (sticky)
//   timeout   : trip budget used up without success (sticky)
//   move_cnt  : legal trips counted, saturating
//   last_item : cargo of last legal trip (0 none, 1 cab, 2 sheep, 3 wolf)
//   phase     : monitor FSM state (0 RUN, 1 DONE, 2 FAIL)
// master = state producer, slave = monitor.
interface wsc_monitor_if #(
    parameter int CNT_W = 5
);
    logic [3:0]       state;
    logic             done;
    logic             error;
    logic             illegal;
    logic             timeout;
    logic [CNT_W-1:0] move_cnt;
    logic [1:0]       last_item;
    logic [1:0]       phase;

    modport master (
        output state,
        input  done, error, illegal, timeout, move_cnt, last_item, phase
    );

    modport slave (
        input  state,
        output done, error, illegal, timeout, move_cnt, last_item, phase
    );
endinterface

// File: rtl/wsc_monitor.sv
// Downstream checker for the wolf/sheep/cabbage river-crossing datapath.
// Samples the crossing state every clock, validates each change as a legal
// boat trip, counts trips and raises sticky status flags.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : wsc_monitor_if.slave (state in; flags, move_cnt, last_item, phase out)
module wsc_monitor #(
    parameter int MAX_MOVES = 15,
    parameter int CNT_W     = 5
) (
    input  logic          clk,
    input  logic          rst,
    wsc_monitor_if.slave  bus
);
    typedef enum logic [1:0] {
        PH_RUN  = 2'd0,
        PH_DONE = 2'd1,
        PH_FAIL = 2'd2
    } phase_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_MOVES);

    phase_t           phase_q,      phase_d;
    logic [3:0]       prev_state_q, prev_state_d;
    logic             done_q,       done_d;
    logic             error_q,      error_d;
    logic             illegal_q,    illegal_d;
    logic             timeout_q,    timeout_d;
    logic [CNT_W-1:0] move_cnt_q,   move_cnt_d;
    logic [1:0]       last_item_q,  last_item_d;

    logic [3:0]       diff;
    logic [1:0]       moved_cnt;
    logic             rode_ok;
    logic             legal;
    logic             eaten;
    logic [CNT_W-1:0] cnt_inc;
    logic [1:0]       cargo;

    always_comb begin
        phase_d      = phase_q;
        prev_state_d = prev_state_q;
        done_d       = done_q;
        error_d      = error_q;
        illegal_d    = illegal_q;
        timeout_d    = timeout_q;
        move_cnt_d   = move_cnt_q;
        last_item_d  = last_item_q;

        diff      = bus.state ^ prev_state_q;
        moved_cnt = {1'b0, diff[2]} + {1'b0, diff[1]} + {1'b0, diff[0]};
        // Every item that moved must have started on the farmer's bank.
        rode_ok   = &(~diff[2:0] | ~(prev_state_q[2:0] ^ {3{prev_state_q[3]}}));
        legal     = diff[3] && (moved_cnt <= 2'd1) && rode_ok;

        // Eating is judged on the new state: unattended pairs on the far
        // side of the farmer.
        eaten = ((bus.state[2] == bus.state[1]) && (bus.state[1] != bus.state[3])) ||
                ((bus.state[1] == bus.state[0]) && (bus.state[0] != bus.state[3]));

        cnt_inc = (move_cnt_q != CNT_MAX) ? (move_cnt_q + CNT_W'(1)) : move_cnt_q;

        if (diff[2])      cargo = 2'd3;
        else if (diff[1]) cargo = 2'd2;
        else if (diff[0]) cargo = 2'd1;
        else              cargo = 2'd0;

        if ((phase_q == PH_RUN) && (diff != 4'h0)) begin
            prev_state_d = bus.state;
            if (!legal) begin
                illegal_d = 1'b1;
                phase_d   = PH_FAIL;
            end else begin
                move_cnt_d  = cnt_inc;
                last_item_d = cargo;
                if (eaten) begin
                    error_d = 1'b1;
                    phase_d = PH_FAIL;
                end else if (bus.state == 4'hF) begin
                    done_d  = 1'b1;
                    phase_d = PH_DONE;
                end else if (cnt_inc == CNT_LIMIT) begin
                    timeout_d = 1'b1;
                    phase_d   = PH_FAIL;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q      <= PH_RUN;
            prev_state_q <= 4'h0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            illegal_q    <= 1'b0;
            timeout_q    <= 1'b0;
            move_cnt_q   <= '0;
            last_item_q  <= 2'd0;
        end else begin
            phase_q      <= phase_d;
            prev_state_q <= prev_state_d;
            done_q       <= done_d;
            error_q      <= error_d;
            illegal_q    <= illegal_d;
            timeout_q    <= timeout_d;
            move_cnt_q   <= move_cnt_d;
            last_item_q  <= last_item_d;
        end
    end

    assign bus.done      = done_q;
    assign bus.error     = error_q;
    assign bus.illegal   = illegal_q;
    assign bus.timeout   = timeout_q;
    assign bus.move_cnt  = move_cnt_q;
    assign bus.last_item = last_item_q;
    assign bus.phase     = phase_q;
endmodule

// File: tb/tb_wsc_monitor.sv
// Directed bench for wsc_monitor: default budget (ifa), budget 4 (ifb) and
// budget 7 (ifc, done exactly on the last allowed trip).
module tb_wsc_monitor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    wsc_monitor_if #(.CNT_W(5)) ifa ();
    wsc_monitor_if #(.CNT_W(3)) ifb ();
    wsc_monitor_if #(.CNT_W(3)) ifc ();

    wsc_monitor #(.MAX_MOVES(15), .CNT_W(5)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    wsc_monitor #(.MAX_MOVES(4),  .CNT_W(3)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
    wsc_monitor #(.MAX_MOVES(7),  .CNT_W(3)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

    always #5 clk = ~clk;

    logic [3:0] seq [7];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string t, input logic d, input logic e, input logic il,
                         input logic to, input logic [4:0] c, input logic [1:0] li,
                         input logic [1:0] ph);
        chk({t, ".done"},      {31'd0, ifa.done},      {31'd0, d});
        chk({t, ".error"},     {31'd0, ifa.error},     {31'd0, e});
        chk({t, ".illegal"},   {31'd0, ifa.illegal},   {31'd0, il});
        chk({t, ".timeout"},   {31'd0, ifa.timeout},   {31'd0, to});
        chk({t, ".move_cnt"},  {27'd0, ifa.move_cnt},  {27'd0, c});
        chk({t, ".last_item"}, {30'd0, ifa.last_item}, {30'd0, li});
        chk({t, ".phase"},     {30'd0, ifa.phase},     {30'd0, ph});
        $display("txn %s: done=%0b err=%0b ill=%0b to=%0b cnt=%0d last=%0d phase=%0d",
                 t, ifa.done, ifa.error, ifa.illegal, ifa.timeout, ifa.move_cnt,
                 ifa.last_item, ifa.phase);
    endtask

    task automatic do_reset(input logic [3:0] init);
        @(negedge clk);
        rst = 1'b1;
        ifa.state = init;
        ifc.state = init;
        ifb.state = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic step_ac(input logic [3:0] v, input int n);
        @(negedge clk);
        ifa.state = v;
        ifc.state = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic [3:0] v, input int n);
        @(negedge clk);
        ifb.state = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        seq[0] = 4'hA; seq[1] = 4'h2; seq[2] = 4'hE; seq[3] = 4'h4;
        seq[4] = 4'hD; seq[5] = 4'h5; seq[6] = 4'hF;
        ifa.state = 4'h0;
        ifb.state = 4'h0;
        ifc.state = 4'h0;

        // Reset state
        do_reset(4'h0);
        chk_a("reset", 0, 0, 0, 0, 5'd0, 2'd0, 2'd0);
        chk("reset.b.phase", {30'd0, ifb.phase}, 32'd0);

        // Test 1: classic solution; ifc has budget 7 and must report done, not timeout
        for (int i = 0; i < 7; i++) step_ac(seq[i], 2);
        chk_a("t1_classic", 1, 0, 0, 0, 5'd7, 2'd2, 2'd1);
        chk("t1.c.done",    {31'd0, ifc.done},    32'd1);
        chk("t1.c.timeout", {31'd0, ifc.timeout}, 32'd0);
        chk("t1.c.phase",   {30'd0, ifc.phase},   32'd1);
        step_ac(4'h0, 2);
        chk_a("t1_frozen", 1, 0, 0, 0, 5'd7, 2'd2, 2'd1);

        // Test 2: farmer takes wolf, sheep eats cabbage
        do_reset(4'h0);
        step_ac(4'hC, 2);
        chk_a("t2_eaten", 0, 1, 0, 0, 5'd1, 2'd3, 2'd2);

        // Test 3: cabbage alone, two items, glitch, already-F
        do_reset(4'h0);
        step_ac(4'h1, 2);
        chk_a("t3_alone", 0, 0, 1, 0, 5'd0, 2'd0, 2'd2);
        do_reset(4'h0);
        step_ac(4'hB, 2);
        chk_a("t3_two", 0, 0, 1, 0, 5'd0, 2'd0, 2'd2);
        do_reset(4'h0);
        step_ac(4'h6, 2);
        chk_a("t3_glitch", 0, 0, 1, 0, 5'd0, 2'd0, 2'd2);
        do_reset(4'hF);
        chk_a("t3_startF", 0, 0, 1, 0, 5'd0, 2'd0, 2'd2);

        // Test 4: budget 4 on ifb
        do_reset(4'h0);
        step_b(4'hA, 2);
        step_b(4'h2, 2);
        step_b(4'hA, 2);
        chk("t4.3.cnt",     {29'd0, ifb.move_cnt}, 32'd3);
        chk("t4.3.timeout", {31'd0, ifb.timeout},  32'd0);
        chk("t4.3.phase",   {30'd0, ifb.phase},    32'd0);
        step_b(4'h2, 2);
        chk("t4.4.cnt",     {29'd0, ifb.move_cnt},  32'd4);
        chk("t4.4.timeout", {31'd0, ifb.timeout},   32'd1);
        chk("t4.4.phase",   {30'd0, ifb.phase},     32'd2);
        chk("t4.4.last",    {30'd0, ifb.last_item}, 32'd0);
        chk("t4.4.illegal", {31'd0, ifb.illegal},   32'd0);
        $display("txn t4_timeout: to=%0b cnt=%0d phase=%0d", ifb.timeout, ifb.move_cnt, ifb.phase);
        step_b(4'hA, 2);
        step_b(4'h6, 2);
        chk("t4.fz.cnt",     {29'd0, ifb.move_cnt}, 32'd4);
        chk("t4.fz.illegal", {31'd0, ifb.illegal},  32'd0);
        chk("t4.fz.timeout", {31'd0, ifb.timeout},  32'd1);

        // Test 5: async reset mid-run, then replay
        do_reset(4'h0);
        for (int i = 0; i < 3; i++) step_ac(seq[i], 2);
        chk_a("t5_pre", 0, 0, 0, 0, 5'd3, 2'd3, 2'd0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_a("t5_async", 0, 0, 0, 0, 5'd0, 2'd0, 2'd0);
        ifa.state = 4'h0;
        ifc.state = 4'h0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 7; i++) step_ac(seq[i], 2);
        chk_a("t5_replay", 1, 0, 0, 0, 5'd7, 2'd2, 2'd1);

        // Test 6: idle cycles between trips
        do_reset(4'h0);
        for (int i = 0; i < 7; i++) begin
            step_ac(seq[i], 4);
            if (i == 1) chk_a("t6_mid", 0, 0, 0, 0, 5'd2, 2'd0, 2'd0);
        end
        chk_a("t6_idle", 1, 0, 0, 0, 5'd7, 2'd2, 2'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
